line_bridge: RTL and testbench

LINE_BRIDGE -- requirements
Module: line_bridge

---
 rtl/line_bridge.sv | 110 +++++++++++
 tb/tb_line_bridge.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/line_bridge.sv
// rtl/line_bridge.sv - splits 128-bit cache line reads/writes into four 32-bit narrow bus beats
module line_bridge #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         proc_reset_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [27:0]  mem_addr,
    input  logic [127:0] mem_wdata,
    output logic [127:0] mem_rdata,
    output logic         mem_ready,
    output logic         nb_req,
    output logic         nb_we,
    output logic [29:0]  nb_addr,
    output logic [31:0]  nb_wdata,
    input  logic [31:0]  nb_rdata,
    input  logic         nb_ack,
    output logic         bus_err
);

    // Sized so ACK_TIMEOUT itself is representable, with at least one bit.
    localparam int WW = $clog2(ACK_TIMEOUT + 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [1:0]      beat;
    logic [WW-1:0]   wait_cnt;
    logic [27:0]     addr_q;
    logic [127:0]    wdata_q;

    logic            ack_hit;
    logic            timeout;
    logic [1:0]      next_beat;

    assign ack_hit   = nb_req && nb_ack;
    assign timeout   = (wait_cnt == WW'(ACK_TIMEOUT));
    assign next_beat = beat + 2'd1;

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state     <= IDLE;
            beat      <= 2'd0;
            wait_cnt  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mem_rdata <= '0;
            mem_ready <= 1'b0;
            nb_req    <= 1'b0;
            nb_we     <= 1'b0;
            nb_addr   <= '0;
            nb_wdata  <= '0;
            bus_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mem_ready <= 1'b0;
                    if (mem_read || mem_write) begin
                        addr_q   <= mem_addr;
                        wdata_q  <= mem_wdata;
                        nb_we    <= mem_write;
                        beat     <= 2'd0;
                        wait_cnt <= '0;
                        nb_req   <= 1'b1;
                        nb_addr  <= {mem_addr, 2'b00};
                        nb_wdata <= mem_wdata[31:0];
                        state    <= BURST;
                    end
                end
                BURST: begin
                    // An ack arriving on the timeout cycle still counts as a real completion.
                    if (ack_hit || timeout) begin
                        if (!nb_we) begin
                            mem_rdata[{beat, 5'b00000} +: 32] <= ack_hit ? nb_rdata : 32'd0;
                        end
                        if (!ack_hit) begin
                            bus_err <= 1'b1;
                        end
                        wait_cnt <= '0;
                        if (beat == 2'd3) begin
                            nb_req    <= 1'b0;
                            mem_ready <= 1'b1;
                            state     <= DONE;
                        end else begin
                            beat     <= next_beat;
                            nb_addr  <= {addr_q, next_beat};
                            nb_wdata <= wdata_q[{next_beat, 5'b00000} +: 32];
                        end
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                DONE: begin
                    // Cache still holds its request here; it is deliberately not sampled.
                    mem_ready <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_bridge.sv
// tb/tb_line_bridge.sv - directed and randomized bench for line_bridge against a line-level model
module tb_line_bridge;

    localparam int TO = 4;

    logic         clk = 1'b0;
    logic         proc_reset_n;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
    logic         nb_req;
    logic         nb_we;
    logic [29:0]  nb_addr;
    logic [31:0]  nb_wdata;
    logic [31:0]  nb_rdata;
    logic         nb_ack;
    logic         bus_err;

    int           vectors = 0;
    int           miscompares = 0;
    logic [31:0]  salt = 32'd0;
    logic [127:0] ref_line = '0;
    logic         ref_err = 1'b0;

    line_bridge #(.ACK_TIMEOUT(TO)) dut (
        .clk          (clk),
        .proc_reset_n (proc_reset_n),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .nb_req       (nb_req),
        .nb_we        (nb_we),
        .nb_addr      (nb_addr),
        .nb_wdata     (nb_wdata),
        .nb_rdata     (nb_rdata),
        .nb_ack       (nb_ack),
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word_of(input logic [29:0] a);
        return {2'b00, a} ^ salt;
    endfunction

    task automatic idle(input int n);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        repeat (n) begin
            nb_ack = 1'($urandom_range(0, 1));
            step();
            chk("idle", {126'd0, mem_ready, nb_req}, 128'd0);
        end
        nb_ack = 1'b0;
    endtask

    // Acts as the narrow slave; waits[b] cycles without ack before ack, any wait beyond TO never acks.
    task automatic do_burst(input logic rd, input logic wr, input logic [27:0] a,
                            input logic [127:0] wd, input int w0, input int w1,
                            input int w2, input int w3);
        int          waits[4];
        int          eff;
        logic [29:0] wa;
        waits     = '{w0, w1, w2, w3};
        mem_read  = rd;
        mem_write = wr;
        mem_addr  = a;
        mem_wdata = wd;
        nb_ack    = 1'b0;
        step();
        for (int b = 0; b < 4; b++) begin
            eff = (waits[b] > TO) ? TO : waits[b];
            wa  = {a, 2'(b)};
            for (int w = 0; w <= eff; w++) begin
                chk("beat", {32'd0, mem_ready, nb_req, nb_we, nb_addr, wr ? nb_wdata : 32'd0},
                    {32'd0, 1'b0, 1'b1, wr, wa, wr ? wd[b*32 +: 32] : 32'd0});
                if (w == waits[b]) begin
                    nb_ack   = 1'b1;
                    nb_rdata = word_of(wa);
                    if (!wr) ref_line[b*32 +: 32] = word_of(wa);
                end else begin
                    nb_ack   = 1'b0;
                    nb_rdata = $urandom;
                end
                step();
            end
            if (waits[b] > TO) begin
                ref_err = 1'b1;
                if (!wr) ref_line[b*32 +: 32] = 32'd0;
            end
        end
        nb_ack = 1'b0;
        chk("done", {126'd0, mem_ready, nb_req}, {126'd0, 1'b1, 1'b0});
        chk("rdata", mem_rdata, ref_line);
        chk("bus_err", {127'd0, bus_err}, {127'd0, ref_err});
        step();
        chk("no_restart", {126'd0, mem_ready, nb_req}, 128'd0);
    endtask

    initial begin
        int sel;
        proc_reset_n = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        nb_rdata     = '0;
        nb_ack       = 1'b0;
        step();
        step();
        chk("rst_rdata", mem_rdata, 128'd0);
        chk("rst_ctl", {62'd0, mem_ready, nb_req, nb_we, nb_addr, nb_wdata, bus_err}, 128'd0);
        proc_reset_n = 1'b1;
        idle(2);

        do_burst(1'b1, 1'b0, 28'd5, '0, 0, 0, 0, 0);
        chk("rd5_line", mem_rdata, {32'd23, 32'd22, 32'd21, 32'd20});
        do_burst(1'b1, 1'b0, 28'd6, '0, 0, 0, 0, 0);
        chk("rd6_line", mem_rdata, {32'd27, 32'd26, 32'd25, 32'd24});
        idle(1);

        do_burst(1'b0, 1'b1, 28'h3, {32'd40, 32'd31, 32'd22, 32'd13}, 2, 2, 2, 2);
        chk("wr_keeps_rdata", mem_rdata, {32'd27, 32'd26, 32'd25, 32'd24});
        idle(1);
        do_burst(1'b1, 1'b1, 28'd0, {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA}, 0, 1, 0, 3);
        idle(1);

        do_burst(1'b1, 1'b0, 28'd1, '0, 0, 0, 100, 0);
        chk("to_word2", {96'd0, mem_rdata[95:64]}, 128'd0);
        idle(1);
        do_burst(1'b1, 1'b0, 28'd7, '0, 1, 0, 4, 0);
        chk("err_sticky", {127'd0, bus_err}, 128'd1);
        idle(1);

        mem_read = 1'b1;
        mem_addr = 28'd9;
        step();
        for (int b = 0; b < 2; b++) begin
            nb_ack   = 1'b1;
            nb_rdata = word_of({28'd9, 2'(b)});
            step();
        end
        nb_ack       = 1'b0;
        proc_reset_n = 1'b0;
        mem_read     = 1'b0;
        #1;
        chk("mid_rst_rdata", mem_rdata, 128'd0);
        chk("mid_rst_ctl", {62'd0, mem_ready, nb_req, nb_we, nb_addr, nb_wdata, bus_err}, 128'd0);
        ref_line = '0;
        ref_err  = 1'b0;
        step();
        step();
        proc_reset_n = 1'b1;
        idle(2);
        do_burst(1'b1, 1'b0, 28'd2, '0, 0, 1, 0, 0);
        chk("rd2_line", mem_rdata, {32'd11, 32'd10, 32'd9, 32'd8});

        salt = $urandom;
        for (int i = 0; i < 24; i++) begin
            idle($urandom_range(1, 3));
            sel = $urandom_range(1, 3);
            do_burst(sel[0], sel[1], 28'($urandom), {$urandom, $urandom, $urandom, $urandom},
                     $urandom_range(0, 5), $urandom_range(0, 5),
                     $urandom_range(0, 5), $urandom_range(0, 5));
        end
        idle(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
